// File: rtl/sha256_pkg.sv
// ============================================================================
// Module   : sha256_pkg
// Brief    : Shared constants and streamer state type for the SHA-256 digest
//            output path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sha256_pkg;

  localparam int DIGEST_BITS  = 256;
  localparam int DIGEST_BYTES = DIGEST_BITS / 8;

  localparam logic [7:0] c_ascii_zero    = 8'h30;
  localparam logic [7:0] c_ascii_lower_a = 8'h61;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_DRAINED = 2'd2
  } stream_state_e;

endpackage

`default_nettype wire

// File: rtl/sha256_digest_streamer_if.sv
// ============================================================================
// Module   : sha256_digest_streamer_if
// Brief    : 8-bit valid/ready byte stream carrying the digest off chip.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sha256_digest_streamer_if;

  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       byte_last;

  modport master (
    output byte_out,
    output byte_valid,
    output byte_last,
    input  byte_ready
  );

  modport slave (
    input  byte_out,
    input  byte_valid,
    input  byte_last,
    output byte_ready
  );

endinterface

`default_nettype wire

// File: rtl/sha256_hex_nibble.sv
// ============================================================================
// Module   : sha256_hex_nibble
// Brief    : Maps a 4-bit nibble to its lowercase ASCII hex character.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sha256_hex_nibble
  import sha256_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  always_comb begin
    if (i_nibble < 4'd10) begin
      o_ascii = c_ascii_zero + {4'b0000, i_nibble};
    end else begin
      o_ascii = c_ascii_lower_a + {4'b0000, i_nibble} - 8'd10;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sha256_digest_streamer.sv
// ============================================================================
// Module   : sha256_digest_streamer
// Brief    : Captures the digest on the first rise of hash_done and streams it
//            MSB byte first over a valid/ready byte interface, with replay.
//            Define SHA256_OUT_HEX_ASCII_EN to emit lowercase ASCII hex pairs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sha256_digest_streamer
  import sha256_pkg::*;
#(
  parameter int DIGEST_BITS = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIGEST_BITS-1:0] hash_in,
  input  logic                   hash_done,
  input  logic                   replay,
  sha256_digest_streamer_if.master stream,
  output logic                   busy,
  output logic                   have_digest
);

  localparam int DIGEST_BYTES = DIGEST_BITS / 8;
`ifdef SHA256_OUT_HEX_ASCII_EN
  localparam int N_XFER = 2 * DIGEST_BYTES;
`else
  localparam int N_XFER = DIGEST_BYTES;
`endif
  localparam int IDX_W    = $clog2(N_XFER);
  localparam int BYTE_W   = $clog2(DIGEST_BYTES);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_XFER - 1);

  stream_state_e          r_state;
  logic [DIGEST_BITS-1:0] r_digest;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_done_prev;
  logic                   r_byte_valid;
  logic                   r_byte_last;
  logic                   r_have_digest;

  logic                   w_capture;
  logic                   w_xfer;
  logic [BYTE_W-1:0]      w_byte_idx;
  logic [7:0]             w_bytes [DIGEST_BYTES];
  logic [7:0]             w_byte;

  assign w_capture = hash_done & ~r_done_prev;
  assign w_xfer    = r_byte_valid & stream.byte_ready;

  // Byte 0 is the most significant byte of the digest.
  for (genvar gi = 0; gi < DIGEST_BYTES; gi++) begin : g_bytes
    assign w_bytes[gi] = r_digest[DIGEST_BITS-1-8*gi -: 8];
  end

`ifdef SHA256_OUT_HEX_ASCII_EN
  logic [3:0] w_nibble;
  logic [7:0] w_char;

  // Even character index carries the high nibble of the byte.
  assign w_byte_idx = r_idx[IDX_W-1:1];
  assign w_byte     = w_bytes[w_byte_idx];
  assign w_nibble   = r_idx[0] ? w_byte[3:0] : w_byte[7:4];

  sha256_hex_nibble u_hex_nibble (
    .i_nibble (w_nibble),
    .o_ascii  (w_char)
  );

  assign stream.byte_out = w_char;
`else
  assign w_byte_idx      = r_idx;
  assign w_byte          = w_bytes[w_byte_idx];
  assign stream.byte_out = w_byte;
`endif

  assign stream.byte_valid = r_byte_valid;
  assign stream.byte_last  = r_byte_last;
  assign busy              = (r_state == ST_SEND);
  assign have_digest       = r_have_digest;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_digest      <= '0;
      r_idx         <= '0;
      r_done_prev   <= 1'b0;
      r_byte_valid  <= 1'b0;
      r_byte_last   <= 1'b0;
      r_have_digest <= 1'b0;
    end else begin
      r_done_prev <= hash_done;
      case (r_state)
        ST_IDLE: begin
          if (w_capture) begin
            r_digest      <= hash_in;
            r_idx         <= '0;
            r_have_digest <= 1'b1;
            r_byte_valid  <= 1'b1;
            r_byte_last   <= (c_last_idx == '0);
            r_state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_xfer) begin
            if (r_idx == c_last_idx) begin
              r_idx        <= '0;
              r_byte_valid <= 1'b0;
              r_byte_last  <= 1'b0;
              r_state      <= ST_DRAINED;
            end else begin
              r_idx       <= r_idx + IDX_W'(1);
              r_byte_last <= ((r_idx + IDX_W'(1)) == c_last_idx);
            end
          end
        end
        ST_DRAINED: begin
          // Capture events are deliberately ignored here: the digest is kept until reset.
          if (replay) begin
            r_idx        <= '0;
            r_byte_valid <= 1'b1;
            r_byte_last  <= (c_last_idx == '0);
            r_state      <= ST_SEND;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_byte_valid <= 1'b0;
          r_byte_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sha256_digest_streamer.sv
// ============================================================================
// Module   : tb_sha256_digest_streamer
// Brief    : Self-checking bench for the digest streamer against a stream model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sha256_digest_streamer;

  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

`ifdef SHA256_OUT_HEX_ASCII_EN
  localparam logic [7:0] RESET_BYTE = 8'h30;
`else
  localparam logic [7:0] RESET_BYTE = 8'h00;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] hash_in;
  logic         hash_done;
  logic         replay;
  logic         busy;
  logic         have_digest;

  sha256_digest_streamer_if s ();

  sha256_digest_streamer dut (
    .clk         (clk),
    .rst         (rst),
    .hash_in     (hash_in),
    .hash_done   (hash_done),
    .replay      (replay),
    .stream      (s),
    .busy        (busy),
    .have_digest (have_digest)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q [$];
  logic [7:0] rx_bytes [$];
  bit         rx_last [$];
  bit         rx_timeout;
  int         hold_err;

  // Expected stream: raw bytes MSB first, or the "%02x" text of each byte.
  function automatic void build_expected(input logic [255:0] d);
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      logic [7:0] b;
      b = d[255-8*i -: 8];
`ifdef SHA256_OUT_HEX_ASCII_EN
      begin
        string h;
        h = $sformatf("%02x", b);
        exp_q.push_back(h[0]);
        exp_q.push_back(h[1]);
      end
`else
      exp_q.push_back(b);
`endif
    end
  endfunction

  function automatic logic [255:0] rand_digest();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  function automatic int count_mismatch();
    int m = 0;
    for (int i = 0; i < rx_bytes.size() && i < exp_q.size(); i++)
      if (rx_bytes[i] !== exp_q[i]) m++;
    return m;
  endfunction

  function automatic int last_flag_pos();
    int pos = -1;
    int n = 0;
    for (int i = 0; i < rx_last.size(); i++)
      if (rx_last[i]) begin pos = i; n++; end
    return (n == 1) ? pos : -2;
  endfunction

  task automatic pulse_replay();
    replay = 1'b1;
    @(posedge clk); #1;
    replay = 1'b0;
  endtask

  // Sink: mode 0 always ready, 1 random ready, 2 three-cycle stall at index 5.
  task automatic collect(input int mode, input int replay_at, input int max_xfers,
                         input int budget);
    int         cyc = 0;
    int         stall_cnt = 0;
    bit         prev_stall = 0;
    bit         did_replay = 0;
    bit         rdy, xfer, lst, prev_l;
    logic [7:0] b, prev_b;
    prev_b = 8'h00; prev_l = 1'b0;
    rx_bytes.delete(); rx_last.delete();
    rx_timeout = 0; hold_err = 0;
    forever begin
      if (cyc >= budget) begin rx_timeout = 1; break; end
      if (prev_stall && (s.byte_valid !== 1'b1 || s.byte_out !== prev_b ||
                         s.byte_last !== prev_l)) hold_err++;
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 2) != 0);
        default: begin
          rdy = !(rx_bytes.size() == 5 && stall_cnt < 3 && s.byte_valid === 1'b1);
          if (!rdy) stall_cnt++;
        end
      endcase
      if (replay_at >= 0 && rx_bytes.size() == replay_at && !did_replay) begin
        replay = 1'b1; did_replay = 1;
      end else begin
        replay = 1'b0;
      end
      s.byte_ready = rdy;
      xfer = (s.byte_valid === 1'b1) && rdy;
      b = s.byte_out; lst = s.byte_last;
      prev_stall = (s.byte_valid === 1'b1) && !rdy;
      prev_b = b; prev_l = lst;
      @(posedge clk); #1; cyc++;
      if (xfer) begin
        rx_bytes.push_back(b);
        rx_last.push_back(lst);
        if (lst) break;
        if (max_xfers > 0 && rx_bytes.size() >= max_xfers) break;
      end
    end
    replay = 1'b0;
    s.byte_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; hash_done = 1'b0; replay = 1'b0; hash_in = '0; s.byte_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (s.byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", s.byte_valid); end
    n_checks++; if (s.byte_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", s.byte_last); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (have_digest !== 1'b0) begin n_fail++; $display("FAIL reset_have: got %b want 0", have_digest); end
    n_checks++; if (s.byte_out !== RESET_BYTE) begin n_fail++; $display("FAIL reset_byte: got %h want %h", s.byte_out, RESET_BYTE); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_full_stream(input string name);
    n_checks++; if (rx_timeout) begin n_fail++; $display("FAIL %s_timeout: got %0d bytes before cycle budget ran out", name, rx_bytes.size()); end
    n_checks++; if (rx_bytes.size() != exp_q.size()) begin n_fail++; $display("FAIL %s_len: got %0d want %0d", name, rx_bytes.size(), exp_q.size()); end
    n_checks++; if (count_mismatch() != 0) begin n_fail++; $display("FAIL %s_data: got %0d wrong bytes want 0", name, count_mismatch()); end
    n_checks++; if (last_flag_pos() != exp_q.size() - 1) begin n_fail++; $display("FAIL %s_last: got last at %0d want %0d", name, last_flag_pos(), exp_q.size() - 1); end
    n_checks++; if (hold_err != 0) begin n_fail++; $display("FAIL %s_hold: got %0d unstable stalls want 0", name, hold_err); end
    n_checks++; if (s.byte_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL %s_after: got valid=%b busy=%b want 0 0", name, s.byte_valid, busy); end
  endtask

  task automatic test_basic();
    hash_in = ABC_DIGEST; build_expected(ABC_DIGEST); s.byte_ready = 1'b1;
    hash_done = 1'b1;
    n_checks++; if (s.byte_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pre_valid: got %b want 0", s.byte_valid); end
    @(posedge clk); #1;
    n_checks++; if (s.byte_valid !== 1'b1 || busy !== 1'b1 || have_digest !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got valid=%b busy=%b have=%b want 1 1 1", s.byte_valid, busy, have_digest); end
    n_checks++; if (s.byte_out !== exp_q[0]) begin n_fail++; $display("FAIL basic_first: got %h want %h", s.byte_out, exp_q[0]); end
    collect(0, -1, 0, 200);
    check_full_stream("basic");
    n_checks++; if (have_digest !== 1'b1) begin n_fail++; $display("FAIL basic_have: got %b want 1", have_digest); end
  endtask

  task automatic test_backpressure();
    pulse_replay();
    collect(2, -1, 0, 200);
    check_full_stream("backpressure");
    n_checks++; if (rx_bytes.size() > 5 && rx_bytes[5] !== exp_q[5]) begin n_fail++; $display("FAIL backpressure_idx5: got %h want %h", rx_bytes[5], exp_q[5]); end
  endtask

  task automatic test_held_done();
    int seen = 0;
    hash_in = '1;
    repeat (8) begin
      @(posedge clk); #1;
      if (s.byte_valid === 1'b1 || busy === 1'b1) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL held_no_restart: got %0d active cycles want 0", seen); end
    // Falling then rising done while drained must not recapture either.
    hash_done = 1'b0;
    @(posedge clk); #1;
    hash_in = rand_digest(); hash_done = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (s.byte_valid === 1'b1) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL recapture_no_restart: got %0d active cycles want 0", seen); end
    pulse_replay();
    collect(1, -1, 0, 400);
    check_full_stream("held_replay");
  endtask

  task automatic test_replay();
    pulse_replay();
    collect(1, 10, 0, 400);
    check_full_stream("replay_midstream");
  endtask

  task automatic test_reset_mid();
    logic [255:0] d;
    int seen = 0;
    pulse_replay();
    collect(0, -1, 10, 100);
    n_checks++; if (rx_bytes.size() != 10) begin n_fail++; $display("FAIL resetmid_partial: got %0d want 10", rx_bytes.size()); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (s.byte_valid !== 1'b0 || busy !== 1'b0 || have_digest !== 1'b0) begin n_fail++; $display("FAIL resetmid_async: got valid=%b busy=%b have=%b want 0 0 0", s.byte_valid, busy, have_digest); end
    hash_done = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    d = rand_digest(); hash_in = d;
    replay = 1'b1;
    @(posedge clk); #1;
    replay = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (s.byte_valid === 1'b1) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL idle_replay: got %0d active cycles want 0", seen); end
    build_expected(d);
    hash_done = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (s.byte_valid !== 1'b1) begin n_fail++; $display("FAIL resetmid_restart: got %b want 1", s.byte_valid); end
    collect(1, -1, 0, 400);
    check_full_stream("resetmid_fresh");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_held_done();
    test_replay();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sha256_digest_streamer.md
Name: sha256_digest_streamer

Overview:
Downstream stage of the SHA-256 processor. Captures the 256-bit digest when the processor's done level first rises. Streams the digest out, MSB byte first, over an 8-bit valid/ready byte interface so it can leave through the narrow output pins. The stored digest can be replayed on request without rehashing.

Parameters:
DIGEST_BITS, 256, width of hash_in; must be a multiple of 8.
DIGEST_BYTES, DIGEST_BITS/8 (32), bytes per stream. Derived; not overridden.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
hash_in  in  256  digest from processor, valid while hash_done high
hash_done  in  1  processor done level; stays high once asserted
replay  in  1  single-cycle request to resend the stored digest
byte_out  out  8  current output byte
byte_valid  out  1  byte_out holds a byte to transfer
byte_ready  in  1  sink accepts byte; transfer = byte_valid & byte_ready
byte_last  out  1  high with the final byte of a stream
busy  out  1  high while in SEND
have_digest  out  1  a digest has been captured since reset

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous, active-high. All state clears immediately on rst.
- Reset values: state=IDLE, digest_q=0, idx=0, done_prev=0, byte_valid=0, byte_last=0, busy=0, have_digest=0. byte_out=0 because digest_q=0 and idx=0.
- Edge detect: done_prev <= hash_done every cycle in every state. A capture event is hash_done & ~done_prev.
- States: IDLE, SEND, DRAINED.
- IDLE, on capture event:
  - digest_q <= hash_in; idx <= 0; have_digest <= 1; state <= SEND.
  - byte_valid rises on the cycle after hash_done is first sampled high (1-cycle latency).
- SEND:
  - byte_out = digest_q[DIGEST_BITS-1-8*idx -: 8], sourced only from registers.
  - byte_valid = 1. byte_last = (idx == DIGEST_BYTES-1).
  - Each transfer advances idx by 1.
  - A transfer at idx == DIGEST_BYTES-1 moves to DRAINED, clears idx, and drops byte_valid and byte_last the next cycle.
  - While byte_valid & ~byte_ready, byte_out, byte_last and idx hold stable.
- DRAINED: byte_valid=0. A replay pulse sets idx <= 0 and state <= SEND; the same digest is resent in full.
- busy = (state == SEND).
- Ignored events:
  - A capture event during SEND or DRAINED. digest_q is never overwritten after capture; a new digest needs a reset, matching the processor, which leaves DONE only on reset.
  - replay in IDLE or SEND.
  - hash_done held high: no recapture.
- idx width: clog2(DIGEST_BYTES) bits, or +1 bit under the optional feature. idx never wraps; the terminal compare is explicit.
- Reset mid-stream: byte_valid drops asynchronously and the partial stream is abandoned. The sink must discard a stream that ends without byte_last.
- byte_ready is ignored whenever byte_valid=0.

Optional Feature:
SHA256_OUT_HEX_ASCII_EN
- Defined: each digest byte goes out as two lowercase ASCII hex characters, high nibble first ('0'-'9' = 0x30-0x39, 'a'-'f' = 0x61-0x66). A stream is 2*DIGEST_BYTES = 64 transfers. idx counts characters; byte_last asserts on character 63.
- Not defined: raw binary, 32 transfers, as above.

Decomposition:
- Shared package sha256_pkg holds:
  - DIGEST_BITS and DIGEST_BYTES constants;
  - the streamer state enum (IDLE/SEND/DRAINED);
  - ASCII constants 0x30 and 0x61 for the hex encoder.
- One combinational sub-module, sha256_hex_nibble, maps a 4-bit nibble to an ASCII byte. It is instantiated only under SHA256_OUT_HEX_ASCII_EN.

Test Plan:
- Basic stream: hash_in = ba7816bf...f20015ad ("abc" digest), hash_done rises, byte_ready=1 throughout -> byte_valid rises 1 cycle later; 32 consecutive bytes 0xba, 0x78, 0x16, 0xbf, ..., 0x15, 0xad; byte_last only on 0xad; byte_valid low afterwards.
- Backpressure: same digest, byte_ready low for 3 cycles at idx 5 -> byte_out holds 0x01 (6th byte) and byte_last stays 0 across the stall; no byte skipped or duplicated; 32 transfers total.
- Held done / recapture: hash_done stays high; hash_in changes to all-ones after capture -> streamed bytes are still the "abc" digest; no second stream starts.
- Replay: after DRAINED, pulse replay -> identical 32-byte stream; a replay pulse mid-stream -> no effect, stream length stays 32.
- Reset mid-stream: assert rst after 10 transfers -> byte_valid, busy and have_digest go 0 immediately; after release with hash_done=0 then rising, a fresh full stream starts at byte 0.
- Hex mode (macro defined): "abc" digest -> 64 transfers beginning 0x62, 0x61, 0x37, 0x38 and ending 0x61, 0x64; byte_last on the 64th.
